// File: rtl/mem_pll_reset_sequencer.sv
// Memory-clock PLL reset sequencer running on the board reference clock.
// Qualifies PLL lock, releases the memory-domain reset, and parks after repeated lock failures.
module mem_pll_reset_sequencer #(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 50000,
  parameter int unsigned LOCK_STABLE    = 1024,
  parameter int unsigned RELEASE_DELAY  = 64,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned CNT_W          = 16
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked_in,
  input  logic       retry_req,
  output logic       pll_rst,
  output logic       mem_rst,
  output logic       ready,
  output logic       fault,
  output logic [7:0] loss_cnt,
  output logic [2:0] state_o
);

  localparam int unsigned RetW = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0] PrstLast    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] StableLast  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] ReleaseLast = CNT_W'(RELEASE_DELAY - 1);
  localparam logic [RetW-1:0]  RetMax      = RetW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    StPrst  = 3'd0,
    StWait  = 3'd1,
    StStab  = 3'd2,
    StRel   = 3'd3,
    StRun   = 3'd4,
    StFault = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RetW-1:0]  retries_q, retries_d, retries_inc;
  logic [7:0]       loss_d;
  logic             sync_q, lk;
  logic             attempt_fail;

  // locked_in is asynchronous to refclk.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync_q <= 1'b0;
      lk     <= 1'b0;
    end else begin
      sync_q <= locked_in;
      lk     <= sync_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_W'(1);
    retries_d    = retries_q;
    retries_inc  = retries_q + RetW'(1);
    loss_d       = loss_cnt;
    attempt_fail = 1'b0;

    unique case (state_q)
      StPrst: begin
        if (cnt_q == PrstLast) state_d = StWait;
      end
      StWait: begin
        // Lock wins over a coincident timeout.
        if (lk)                          state_d = StStab;
        else if (cnt_q == TimeoutLast)   attempt_fail = 1'b1;
      end
      StStab: begin
        if (!lk)                         state_d = StWait;
        else if (cnt_q == StableLast)    state_d = StRel;
      end
      StRel: begin
        if (!lk) begin
          attempt_fail = 1'b1;
        end else if (cnt_q == ReleaseLast) begin
          state_d   = StRun;
          retries_d = '0;
        end
      end
      StRun: begin
        cnt_d = cnt_q;
        if (!lk) begin
          state_d = StPrst;
          if (loss_cnt != 8'hff) loss_d = loss_cnt + 8'd1;
        end
      end
      StFault: begin
        cnt_d = cnt_q;
        if (retry_req) begin
          state_d   = StPrst;
          retries_d = '0;
        end
      end
      default: state_d = StPrst;
    endcase

    if (attempt_fail) begin
      retries_d = retries_inc;
      state_d   = (retries_inc == RetMax) ? StFault : StPrst;
    end

    // Every state entry restarts the cycle counter.
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= StPrst;
      cnt_q     <= '0;
      retries_q <= '0;
      loss_cnt  <= 8'd0;
      pll_rst   <= 1'b1;
      mem_rst   <= 1'b1;
      ready     <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retries_q <= retries_d;
      loss_cnt  <= loss_d;
      pll_rst   <= (state_d == StPrst) || (state_d == StFault);
      mem_rst   <= (state_d != StRun);
      ready     <= (state_d == StRun);
      fault     <= (state_d == StFault);
    end
  end

  assign state_o = state_q;

endmodule
